// File: rtl/cell_window_gen_if.sv
// Cell stream in, 3x3 neighbourhood window out; in_last/frame_err exist only with CELL_WINDOW_FRAME_CHECK_EN.
interface cell_window_gen_if;
    logic in_valid;
    logic in_ready;
    logic in_cell;
    logic out_valid;
    logic out_ready;
    logic n, ne, e, se, s, sw, w, nw;
    logic center;
    logic out_last;
`ifdef CELL_WINDOW_FRAME_CHECK_EN
    logic in_last;
    logic frame_err;

    modport master (
        output in_valid, in_cell, in_last, out_ready,
        input  in_ready, out_valid, n, ne, e, se, s, sw, w, nw, center, out_last, frame_err
    );
    modport slave (
        input  in_valid, in_cell, in_last, out_ready,
        output in_ready, out_valid, n, ne, e, se, s, sw, w, nw, center, out_last, frame_err
    );
`else
    modport master (
        output in_valid, in_cell, out_ready,
        input  in_ready, out_valid, n, ne, e, se, s, sw, w, nw, center, out_last
    );
    modport slave (
        input  in_valid, in_cell, out_ready,
        output in_ready, out_valid, n, ne, e, se, s, sw, w, nw, center, out_last
    );
`endif
endinterface

// File: rtl/cell_window_gen.sv
// Game-of-Life neighbourhood generator (optional CELL_WINDOW_FRAME_CHECK_EN); window valid 1 cycle after cell k+W+1.
// Registered outputs hold while out_valid && !out_ready; in_ready drops when stalled or while flushing.
module cell_window_gen #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input logic              clk,
    input logic              rst,
    cell_window_gen_if.slave bus
);
    localparam int SRW  = 2*WIDTH + 3;
    localparam int CNTW = $clog2(WIDTH*HEIGHT);
    localparam int RW   = $clog2(HEIGHT);
    localparam int CW   = $clog2(WIDTH);
    localparam int FW   = $clog2(WIDTH + 1);

    localparam logic [CNTW-1:0] LAST_IDX   = CNTW'(WIDTH*HEIGHT - 1);
    localparam logic [CNTW-1:0] FILL_IDX   = CNTW'(WIDTH);
    localparam logic [RW-1:0]   LAST_ROW   = RW'(HEIGHT - 1);
    localparam logic [CW-1:0]   LAST_COL   = CW'(WIDTH - 1);
    localparam logic [FW-1:0]   FLUSH_LAST = FW'(WIDTH);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [SRW-2:0]  sr;
    logic [SRW-1:0]  sr_nxt;
    logic [CNTW-1:0] in_cnt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [FW-1:0]   flush_cnt;
    logic            out_valid_q, out_last_q;
    logic [8:0]      win_q, win_nxt;
    logic            advance, accept, step, shift, shift_bit, in_ready_c;
    logic            top, bot, lft, rgt;

    assign advance = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            FILL: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
                if (accept && in_cnt == FILL_IDX) state_nxt = RUN;
            end
            RUN: begin
                in_ready_c = advance;
                accept     = bus.in_valid && advance;
                step       = accept;
                if (accept && in_cnt == LAST_IDX) state_nxt = FLUSH;
            end
            FLUSH: begin
                step = advance;
                if (step && flush_cnt == FLUSH_LAST) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    assign shift     = accept || step;
    assign shift_bit = accept ? bus.in_cell : 1'b0;
    assign sr_nxt    = {sr, shift_bit};

    // Window is taken from the post-shift view so it lands on the producing edge.
    assign top = (row != '0);
    assign bot = (row != LAST_ROW);
    assign lft = (col != '0);
    assign rgt = (col != LAST_COL);

    assign win_nxt = {
        top        & sr_nxt[2*WIDTH+1],
        top & rgt  & sr_nxt[2*WIDTH],
        rgt        & sr_nxt[WIDTH],
        bot & rgt  & sr_nxt[0],
        bot        & sr_nxt[1],
        bot & lft  & sr_nxt[2],
        lft        & sr_nxt[WIDTH+2],
        top & lft  & sr_nxt[2*WIDTH+2],
        sr_nxt[WIDTH+1]
    };

    // The oldest shift-register bit is only consumed in its loading cycle, so it is not stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr          <= '0;
            in_cnt      <= '0;
            row         <= '0;
            col         <= '0;
            flush_cnt   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            win_q       <= '0;
        end else begin
            if (shift) sr <= sr_nxt[SRW-2:0];
            if (accept) in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
            if (step) begin
                win_q       <= win_nxt;
                out_valid_q <= 1'b1;
                out_last_q  <= (row == LAST_ROW) && (col == LAST_COL);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (state == FLUSH)
                    flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef CELL_WINDOW_FRAME_CHECK_EN
    logic frame_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_err_q <= 1'b0;
        else if (accept && (bus.in_last != (in_cnt == LAST_IDX)))
            frame_err_q <= 1'b1;
    end

    assign bus.frame_err = frame_err_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign {bus.n, bus.ne, bus.e, bus.se, bus.s, bus.sw, bus.w, bus.nw, bus.center} = win_q;
endmodule

// File: tb/tb_cell_window_gen.sv
// Directed and randomised-handshake bench for cell_window_gen on an 8x8 board.
module tb_cell_window_gen;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W*H;
    localparam int LIMIT = 20000;

    typedef logic [9:0] win_t;  // {out_last, n, ne, e, se, s, sw, w, nw, center}
    typedef struct {
        int         pat;
        int         r;
        int         c;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cell_window_gen_if bus ();
    cell_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic cells[$];
    win_t got[$];
    int   total = 0;
    int   bad = 0;
    int   stall_viol = 0;
    int   lat_acc10, lat_ov;
    int   last_pos = -1;
    bit   fe_watch = 1'b0;
    vec_t tbl[18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic cellat(input int base, input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
        return cells[base + r*W + c];
    endfunction

    function automatic win_t model(input int base, input int k);
        int r;
        int c;
        r = k / W;
        c = k % W;
        return {(k == N-1) ? 1'b1 : 1'b0,
                cellat(base, r-1, c),   cellat(base, r-1, c+1), cellat(base, r, c+1),
                cellat(base, r+1, c+1), cellat(base, r+1, c),   cellat(base, r+1, c-1),
                cellat(base, r, c-1),   cellat(base, r-1, c-1), cellat(base, r, c)};
    endfunction

    function automatic win_t cur_win();
        return {bus.out_last, bus.n, bus.ne, bus.e, bus.se, bus.s, bus.sw, bus.w, bus.nw, bus.center};
    endfunction

    // Feeds cells[0..nbits-1], collects windows into got; stops early after abort_after acceptances.
    task automatic run(input int nbits, input bit rv, input bit rr, input int abort_after);
        int   fed = 0;
        int   cyc = 0;
        bit   flushing = 1'b0;
        int   fl_cycles = 0;
        int   fl_viol = 0;
        bit   prev_stall = 1'b0;
        win_t prev_w = '0;
        win_t cur;
        int   fe_at = -1;
        lat_acc10 = -1;
        lat_ov = -1;
        while (cyc < LIMIT) begin
            @(negedge clk);
            bus.in_valid  = (fed < nbits) && (!rv || $urandom_range(1) == 1);
            bus.in_cell   = (fed < nbits) ? cells[fed] : 1'b0;
            bus.out_ready = !rr || $urandom_range(1) == 1;
`ifdef CELL_WINDOW_FRAME_CHECK_EN
            bus.in_last = (last_pos >= 0) && ((fed % N) == last_pos);
`endif
            #1;
            cur = cur_win();
`ifdef CELL_WINDOW_FRAME_CHECK_EN
            if (fe_at == cyc) check("frame_err_next_cycle", bus.frame_err, 1);
`endif
            if (prev_stall && (!bus.out_valid || cur != prev_w)) stall_viol++;
            if (flushing) begin
                if (bus.out_valid && bus.out_last) begin
                    check("flush_in_ready_low", (fl_viol == 0 && fl_cycles >= H+1) ? 1 : 0, 1);
                    flushing = 1'b0;
                end else begin
                    fl_cycles++;
                    if (bus.in_ready) fl_viol++;
                end
            end
            if (bus.out_valid && lat_ov < 0) lat_ov = cyc;
            if (bus.out_valid && bus.out_ready) got.push_back(cur);
            if (bus.in_valid && bus.in_ready) begin
                if (fe_watch && (fed % N) == 40) fe_at = cyc + 1;
                fed++;
                if (fed == W+2 && lat_acc10 < 0) lat_acc10 = cyc;
                if (fed % N == 0) begin
                    flushing  = 1'b1;
                    fl_cycles = 0;
                    fl_viol   = 0;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_w = cur;
            cyc++;
            if (abort_after >= 0 && fed == abort_after) break;
            if (abort_after < 0 && got.size() == nbits) break;
        end
        if (cyc >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL run_timeout: fed %0d windows %0d", fed, got.size());
        end
    endtask

    task automatic check_boards(input int nb, input string tag);
        check({tag, "_count"}, got.size(), nb*N);
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < N; k++)
                if (b*N + k < got.size())
                    check($sformatf("%s_b%0d_k%0d", tag, b, k), got[b*N + k], model(b*N, k));
    endtask

    task automatic add_random_board();
        for (int i = 0; i < N; i++) cells.push_back(1'($urandom_range(1)));
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 9'b000000000};
        tbl[1]  = '{0, 4, 4, 9'b000000000};
        tbl[2]  = '{0, 7, 7, 9'b000000000};
        tbl[3]  = '{1, 0, 0, 9'b001110001};
        tbl[4]  = '{1, 0, 3, 9'b001111101};
        tbl[5]  = '{1, 3, 3, 9'b111111111};
        tbl[6]  = '{1, 7, 7, 9'b100000111};
        tbl[7]  = '{1, 0, 7, 9'b000011101};
        tbl[8]  = '{2, 2, 2, 9'b000100000};
        tbl[9]  = '{2, 2, 3, 9'b000010000};
        tbl[10] = '{2, 2, 4, 9'b000001000};
        tbl[11] = '{2, 3, 2, 9'b001000000};
        tbl[12] = '{2, 3, 3, 9'b000000001};
        tbl[13] = '{2, 3, 4, 9'b000000100};
        tbl[14] = '{2, 4, 2, 9'b010000000};
        tbl[15] = '{2, 4, 3, 9'b100000000};
        tbl[16] = '{2, 4, 4, 9'b000000010};
        tbl[17] = '{2, 5, 5, 9'b000000000};

        bus.in_valid  = 1'b0;
        bus.in_cell   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef CELL_WINDOW_FRAME_CHECK_EN
        bus.in_last = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_window", cur_win(), 0);

        // Three directed boards back to back: zeros, ones, single live cell at (3,3).
        for (int i = 0; i < N; i++) cells.push_back(1'b0);
        for (int i = 0; i < N; i++) cells.push_back(1'b1);
        for (int i = 0; i < N; i++) cells.push_back((i == 3*W + 3) ? 1'b1 : 1'b0);
        run(3*N, 1'b0, 1'b0, -1);
        check("first_valid_latency", lat_ov - lat_acc10, 1);
        for (int i = 0; i < 18; i++)
            if (tbl[i].pat*N + tbl[i].r*W + tbl[i].c < got.size())
                check($sformatf("tbl%0d_r%0d_c%0d", i, tbl[i].r, tbl[i].c),
                      got[tbl[i].pat*N + tbl[i].r*W + tbl[i].c][8:0], tbl[i].exp);
        begin
            int live = 0;
            int lasts = 0;
            for (int k = 0; k < N && 2*N + k < got.size(); k++)
                if (got[2*N + k][8:0] != 0) live++;
            for (int k = 0; k < N && k < got.size(); k++)
                if (got[k][9]) lasts++;
            check("single_cell_live_windows", live, 9);
            check("zero_board_out_last_count", lasts, 1);
        end
        check_boards(3, "directed");

        // Random handshakes on both sides over three random boards.
        got.delete();
        cells.delete();
        repeat (3) add_random_board();
        stall_viol = 0;
        run(3*N, 1'b1, 1'b1, -1);
        check("stall_hold", stall_viol, 0);
        check_boards(3, "random");

        // Abort a board mid-stream, then a clean board must come out intact.
        got.delete();
        cells.delete();
        add_random_board();
        run(N, 1'b0, 1'b0, 30);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        cells.delete();
        add_random_board();
        run(N, 1'b0, 1'b1, -1);
        check_boards(1, "post_abort");

`ifdef CELL_WINDOW_FRAME_CHECK_EN
        got.delete();
        cells.delete();
        add_random_board();
        last_pos = 40;
        fe_watch = 1'b1;
        run(N, 1'b0, 1'b0, -1);
        check("frame_err_sticky", bus.frame_err, 1);
        fe_watch = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        last_pos = N - 1;
        run(N, 1'b0, 1'b0, -1);
        check("frame_err_clean_board", bus.frame_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
